// File: rtl/sim_tsi_fifo_bridge.sv
// rtl/sim_tsi_fifo_bridge.sv - width-converting FIFO bridge between a target word stream and a 32-bit host beat stream
module sim_tsi_fifo_bridge #(
    parameter int CHIPID    = 0,
    parameter int WIDTH     = 32,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4,
    parameter int TICK_DIV  = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           tsi_out_valid,
    output logic                           tsi_out_ready,
    input  logic [WIDTH-1:0]               tsi_out_bits,
    output logic                           tsi_in_valid,
    input  logic                           tsi_in_ready,
    output logic [WIDTH-1:0]               tsi_in_bits,
    output logic                           host_out_valid,
    input  logic                           host_out_ready,
    output logic [31:0]                    host_out_bits,
    input  logic                           host_in_valid,
    output logic                           host_in_ready,
    input  logic [31:0]                    host_in_bits,
    input  logic [31:0]                    host_exit,
    output logic [31:0]                    exit,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_level,
    output logic [$clog2(IN_DEPTH+1)-1:0]  in_level
);
    localparam int BEATS = WIDTH / 32;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OPW   = $clog2(OUT_DEPTH);
    localparam int IPW   = $clog2(IN_DEPTH);
    localparam int OLW   = $clog2(OUT_DEPTH + 1);
    localparam int ILW   = $clog2(IN_DEPTH + 1);

    // CHIPID is consumed only by the host-side DPI wrapper.
    if (CHIPID < 0) begin : g_chipid_tag
    end

    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;

    logic [WIDTH-1:0] r_out_mem [OUT_DEPTH];
    logic [OPW-1:0]   r_out_wr;
    logic [OPW-1:0]   r_out_rd;
    logic [OLW-1:0]   r_out_level;
    logic [BW-1:0]    r_b;
    logic             w_b_last;
    logic             w_out_push;
    logic             w_out_beat;
    logic             w_out_pop;

    logic [WIDTH-1:0] r_in_mem [IN_DEPTH];
    logic [IPW-1:0]   r_in_wr;
    logic [IPW-1:0]   r_in_rd;
    logic [ILW-1:0]   r_in_level;
    logic [BW-1:0]    r_a;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] w_asm_word;
    logic             w_a_last;
    logic             w_in_beat;
    logic             w_in_push;
    logic             w_in_pop;

    logic [31:0]      r_exit;

    // Host-side rate divider: tick on count 0, so the first cycle out of reset is a tick.
    always_ff @(posedge clock) begin
        if (reset || r_tick_cnt == TW'(TICK_DIV - 1)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = !reset && (r_tick_cnt == '0);

    // Target-to-host path: readiness comes only from registered level, no pop bypass.
    assign tsi_out_ready  = !reset && (r_out_level < OLW'(OUT_DEPTH));
    assign host_out_valid = w_tick && (r_out_level != '0);
    assign host_out_bits  = 32'(r_out_mem[r_out_rd] >> {r_b, 5'b0});
    assign w_b_last       = (r_b == BW'(BEATS - 1));
    assign w_out_push     = tsi_out_valid && tsi_out_ready;
    assign w_out_beat     = host_out_valid && host_out_ready;
    assign w_out_pop      = w_out_beat && w_b_last;
    assign out_level      = r_out_level;

    // Out FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clock) begin
        if (w_out_push) begin
            r_out_mem[r_out_wr] <= tsi_out_bits;
        end
    end

    // Out FIFO pointers, level and serializer beat counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_level <= '0;
            r_b         <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wr <= r_out_wr + 1'b1;
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + 1'b1;
            end
            if (w_out_beat) begin
                r_b <= w_b_last ? '0 : r_b + 1'b1;
            end
            r_out_level <= r_out_level + OLW'(w_out_push) - OLW'(w_out_pop);
        end
    end

    // Host-to-target path: last beat bypasses the assembler straight into the FIFO.
    assign host_in_ready = w_tick && (r_in_level < ILW'(IN_DEPTH));
    assign tsi_in_valid  = !reset && (r_in_level != '0);
    assign tsi_in_bits   = r_in_mem[r_in_rd];
    assign w_a_last      = (r_a == BW'(BEATS - 1));
    assign w_in_beat     = host_in_valid && host_in_ready;
    assign w_in_push     = w_in_beat && w_a_last;
    assign w_in_pop      = tsi_in_valid && tsi_in_ready;
    assign in_level      = r_in_level;

    // Assembled word: earlier beats from the assembler, top beat from the live input.
    always_comb begin
        w_asm_word                  = r_asm;
        w_asm_word[WIDTH-1 -: 32]   = host_in_bits;
    end

    // In FIFO storage.
    always_ff @(posedge clock) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= w_asm_word;
        end
    end

    // In FIFO pointers, level and assembler; reset discards any partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_wr    <= '0;
            r_in_rd    <= '0;
            r_in_level <= '0;
            r_a        <= '0;
            r_asm      <= '0;
        end else begin
            if (w_in_beat) begin
                r_asm <= (r_asm & ~(WIDTH'(32'hFFFF_FFFF) << {r_a, 5'b0}))
                       | (WIDTH'(host_in_bits) << {r_a, 5'b0});
                r_a   <= w_a_last ? '0 : r_a + 1'b1;
            end
            if (w_in_push) begin
                r_in_wr <= r_in_wr + 1'b1;
            end
            if (w_in_pop) begin
                r_in_rd <= r_in_rd + 1'b1;
            end
            r_in_level <= r_in_level + ILW'(w_in_push) - ILW'(w_in_pop);
        end
    end

    // Sticky exit code: first nonzero host value wins until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exit <= '0;
        end else if (r_exit == '0 && host_exit != '0) begin
            r_exit <= host_exit;
        end
    end

    assign exit = r_exit;

endmodule

// File: tb/tb_sim_tsi_fifo_bridge.sv
// tb/tb_sim_tsi_fifo_bridge.sv - directed self-checking bench for sim_tsi_fifo_bridge
module tb_sim_tsi_fifo_bridge;
    logic        clock;
    logic        reset;
    logic        tsi_out_valid;
    logic        tsi_out_ready;
    logic [63:0] tsi_out_bits;
    logic        tsi_in_valid;
    logic        tsi_in_ready;
    logic [63:0] tsi_in_bits;
    logic        host_out_valid;
    logic        host_out_ready;
    logic [31:0] host_out_bits;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [31:0] host_in_bits;
    logic [31:0] host_exit;
    logic [31:0] exit_code;
    logic [2:0]  out_level;
    logic [2:0]  in_level;

    logic        d4_tsi_out_ready;
    logic        d4_tsi_in_valid;
    logic [63:0] d4_tsi_in_bits;
    logic        d4_host_out_valid;
    logic [31:0] d4_host_out_bits;
    logic        d4_host_in_valid;
    logic        d4_host_in_ready;
    logic [31:0] d4_exit;
    logic [2:0]  d4_out_level;
    logic [2:0]  d4_in_level;

    int checks;
    int errors;

    sim_tsi_fifo_bridge #(
        .CHIPID(0), .WIDTH(64), .OUT_DEPTH(4), .IN_DEPTH(4), .TICK_DIV(1)
    ) u_dut (
        .clock(clock), .reset(reset),
        .tsi_out_valid(tsi_out_valid), .tsi_out_ready(tsi_out_ready), .tsi_out_bits(tsi_out_bits),
        .tsi_in_valid(tsi_in_valid), .tsi_in_ready(tsi_in_ready), .tsi_in_bits(tsi_in_bits),
        .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_bits(host_out_bits),
        .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_bits(host_in_bits),
        .host_exit(host_exit), .exit(exit_code),
        .out_level(out_level), .in_level(in_level)
    );

    sim_tsi_fifo_bridge #(
        .CHIPID(1), .WIDTH(64), .OUT_DEPTH(4), .IN_DEPTH(4), .TICK_DIV(4)
    ) u_div4 (
        .clock(clock), .reset(reset),
        .tsi_out_valid(1'b0), .tsi_out_ready(d4_tsi_out_ready), .tsi_out_bits(64'h0),
        .tsi_in_valid(d4_tsi_in_valid), .tsi_in_ready(1'b1), .tsi_in_bits(d4_tsi_in_bits),
        .host_out_valid(d4_host_out_valid), .host_out_ready(1'b0), .host_out_bits(d4_host_out_bits),
        .host_in_valid(d4_host_in_valid), .host_in_ready(d4_host_in_ready), .host_in_bits(32'h1234_5678),
        .host_exit(32'h0), .exit(d4_exit),
        .out_level(d4_out_level), .in_level(d4_in_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (tsi_out_ready !== 1'b0) begin errors++; $display("FAIL reset_tsi_out_ready: got %b expected 0", tsi_out_ready); end
        checks++;
        if (host_in_ready !== 1'b0) begin errors++; $display("FAIL reset_host_in_ready: got %b expected 0", host_in_ready); end
        checks++;
        if (host_out_valid !== 1'b0 || tsi_in_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got %b%b expected 00", host_out_valid, tsi_in_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_level !== 3'd0 || in_level !== 3'd0) begin
            errors++; $display("FAIL reset_levels: got %0d/%0d expected 0/0", out_level, in_level);
        end
        checks++;
        if (exit_code !== 32'd0) begin errors++; $display("FAIL reset_exit: got %h expected 0", exit_code); end
        checks++;
        if (host_in_ready !== 1'b1 || tsi_out_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: got %b%b expected 11", host_in_ready, tsi_out_ready);
        end
    endtask

    task automatic test_out_path();
        host_out_ready = 1'b1;
        tsi_out_valid  = 1'b1;
        tsi_out_bits   = 64'h1122_3344_5566_7788;
        #1;
        checks++;
        if (host_out_valid !== 1'b0) begin errors++; $display("FAIL out_same_cycle_valid: got %b expected 0", host_out_valid); end
        step();
        tsi_out_valid = 1'b0;
        #1;
        checks++;
        if (host_out_valid !== 1'b1 || host_out_bits !== 32'h5566_7788) begin
            errors++; $display("FAIL out_beat0: got %b %h expected 1 55667788", host_out_valid, host_out_bits);
        end
        step();
        checks++;
        if (host_out_valid !== 1'b1 || host_out_bits !== 32'h1122_3344) begin
            errors++; $display("FAIL out_beat1: got %b %h expected 1 11223344", host_out_valid, host_out_bits);
        end
        step();
        checks++;
        if (out_level !== 3'd0 || host_out_valid !== 1'b0) begin
            errors++; $display("FAIL out_drained: got level %0d valid %b expected 0 0", out_level, host_out_valid);
        end
    endtask

    task automatic test_in_path();
        tsi_in_ready  = 1'b0;
        host_in_valid = 1'b1;
        host_in_bits  = 32'hAAAA_0001;
        step();
        host_in_bits = 32'hBBBB_0002;
        #1;
        checks++;
        if (tsi_in_valid !== 1'b0) begin errors++; $display("FAIL in_early_valid: got %b expected 0", tsi_in_valid); end
        step();
        host_in_valid = 1'b0;
        #1;
        checks++;
        if (tsi_in_valid !== 1'b1 || tsi_in_bits !== 64'hBBBB_0002_AAAA_0001) begin
            errors++; $display("FAIL in_word: got %b %h expected 1 bbbb0002aaaa0001", tsi_in_valid, tsi_in_bits);
        end
        tsi_in_ready = 1'b1;
        step();
        tsi_in_ready = 1'b0;
        checks++;
        if (in_level !== 3'd0 || tsi_in_valid !== 1'b0) begin
            errors++; $display("FAIL in_pop: got level %0d valid %b expected 0 0", in_level, tsi_in_valid);
        end
    endtask

    task automatic test_back_to_back();
        host_in_valid = 1'b1;
        host_in_bits  = 32'h0000_00A0;
        step();
        host_in_bits = 32'h0000_00A1;
        step();
        host_in_bits = 32'h0000_00B0;
        step();
        host_in_bits = 32'h0000_00B1;
        tsi_in_ready = 1'b1;
        #1;
        checks++;
        if (tsi_in_bits !== 64'h0000_00A1_0000_00A0 || in_level !== 3'd1) begin
            errors++; $display("FAIL b2b_head_x: got %h level %0d expected 000000a1000000a0 1", tsi_in_bits, in_level);
        end
        step();
        host_in_valid = 1'b0;
        tsi_in_ready  = 1'b0;
        #1;
        checks++;
        if (tsi_in_bits !== 64'h0000_00B1_0000_00B0 || in_level !== 3'd1) begin
            errors++; $display("FAIL b2b_head_y: got %h level %0d expected 000000b1000000b0 1", tsi_in_bits, in_level);
        end
        tsi_in_ready = 1'b1;
        step();
        tsi_in_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] words [5];
        logic [31:0] exp_beats [10];
        int got;
        bit held_ok;
        bit rose;
        bit w4_taken;
        for (int i = 0; i < 5; i++) begin
            words[i]           = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
            exp_beats[2*i]     = 32'h2000_0000 + 32'(i);
            exp_beats[2*i + 1] = 32'h1000_0000 + 32'(i);
        end
        host_out_ready = 1'b0;
        tsi_out_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tsi_out_bits = words[i];
            step();
        end
        tsi_out_bits = words[4];
        #1;
        checks++;
        if (out_level !== 3'd4 || tsi_out_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: got level %0d ready %b expected 4 0", out_level, tsi_out_ready);
        end
        step();
        step();
        checks++;
        if (out_level !== 3'd4) begin errors++; $display("FAIL bp_held: got level %0d expected 4", out_level); end
        host_out_ready = 1'b1;
        got      = 0;
        held_ok  = 1'b1;
        rose     = 1'b0;
        w4_taken = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            #1;
            if (cyc < 2 && tsi_out_ready !== 1'b0) held_ok = 1'b0;
            if (tsi_out_ready === 1'b1) rose = 1'b1;
            if (host_out_valid === 1'b1) begin
                checks++;
                if (host_out_bits !== exp_beats[got]) begin
                    errors++; $display("FAIL bp_beat%0d: got %h expected %h", got, host_out_bits, exp_beats[got]);
                end
                got++;
            end
            if (tsi_out_valid && tsi_out_ready) w4_taken = 1'b1;
            step();
            if (w4_taken) tsi_out_valid = 1'b0;
        end
        checks++;
        if (got != 10) begin errors++; $display("FAIL bp_beat_count: got %0d expected 10", got); end
        checks++;
        if (!held_ok || !rose) begin
            errors++; $display("FAIL bp_ready_rise: got held %b rose %b expected 1 1", held_ok, rose);
        end
        checks++;
        if (out_level !== 3'd0) begin errors++; $display("FAIL bp_empty: got %0d expected 0", out_level); end
        tsi_out_valid = 1'b0;
    endtask

    task automatic test_exit();
        logic [31:0] seq [4];
        logic [31:0] exp_after [4];
        seq[0] = 32'd0; seq[1] = 32'd3; seq[2] = 32'd5; seq[3] = 32'd0;
        exp_after[0] = 32'd0; exp_after[1] = 32'd3; exp_after[2] = 32'd3; exp_after[3] = 32'd3;
        for (int i = 0; i < 4; i++) begin
            host_exit = seq[i];
            #1;
            if (i == 1) begin
                checks++;
                if (exit_code !== 32'd0) begin errors++; $display("FAIL exit_not_early: got %h expected 0", exit_code); end
            end
            step();
            checks++;
            if (exit_code !== exp_after[i]) begin
                errors++; $display("FAIL exit_seq%0d: got %h expected %h", i, exit_code, exp_after[i]);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (exit_code !== 32'd0) begin errors++; $display("FAIL exit_reset: got %h expected 0", exit_code); end
    endtask

    task automatic test_tick_div();
        d4_host_in_valid = 1'b1;
        reset = 1'b1;
        step();
        #1;
        checks++;
        if (d4_host_in_ready !== 1'b0) begin errors++; $display("FAIL div4_reset_ready: got %b expected 0", d4_host_in_ready); end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if (d4_host_in_ready !== ((k % 4) == 0)) begin
                errors++; $display("FAIL div4_ready_cyc%0d: got %b expected %b", k, d4_host_in_ready, ((k % 4) == 0));
            end
            step();
        end
        d4_host_in_valid = 1'b0;
    endtask

    task automatic test_reset_midword();
        tsi_in_ready  = 1'b0;
        host_in_valid = 1'b1;
        host_in_bits  = 32'hDEAD_0000;
        step();
        host_in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        host_in_valid = 1'b1;
        host_in_bits  = 32'h0000_0001;
        step();
        host_in_bits = 32'h0000_0002;
        step();
        host_in_valid = 1'b0;
        #1;
        checks++;
        if (tsi_in_valid !== 1'b1 || tsi_in_bits !== 64'h0000_0002_0000_0001 || in_level !== 3'd1) begin
            errors++; $display("FAIL midword_reset: got %b %h level %0d expected 1 0000000200000001 1",
                               tsi_in_valid, tsi_in_bits, in_level);
        end
        tsi_in_ready = 1'b1;
        step();
        tsi_in_ready = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        tsi_out_valid    = 1'b0;
        tsi_out_bits     = '0;
        tsi_in_ready     = 1'b0;
        host_out_ready   = 1'b0;
        host_in_valid    = 1'b0;
        host_in_bits     = '0;
        host_exit        = '0;
        d4_host_in_valid = 1'b0;
        test_reset();
        test_out_path();
        test_in_path();
        test_back_to_back();
        test_backpressure();
        test_exit();
        test_tick_div();
        test_reset_midword();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
